// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and count types used by the
// scan counters and the sync/decode stage.
package vga_timing_pkg;

   localparam int unsigned COUNT_W = 10;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FP      = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BP      = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FP      = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BP      = 33;

   localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef logic [COUNT_W-1:0] count_t;

   // All-ones is never a legal count, so it marks "no previous sample".
   localparam count_t SENTINEL = '1;

   typedef struct packed {
      logic h_vis;
      logic v_vis;
      logic h_sync;
      logic v_sync;
   } region_t;

   function automatic int unsigned cmp_width(input int unsigned h_total,
                                             input int unsigned v_total);
      return (h_total >= 1024 || v_total >= 1024) ? 11 : 10;
   endfunction

endpackage

// File: rtl/vga_edge_strobe.sv
// Zero-detect pulse generator: fires once when value_i enters zero, however
// long it then holds there.
module vga_edge_strobe #(
   parameter int unsigned    W         = 10,
   parameter logic [W-1:0]   RESET_VAL = '1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] value_i,
   output logic         edge_o,
   output logic         pulse_o
);

   logic [W-1:0] prev_q;
   logic         pulse_q;

   assign edge_o  = (value_i == '0) && (prev_q != '0);
   assign pulse_o = pulse_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q  <= RESET_VAL;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= value_i;
         pulse_q <= edge_o;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// Registered VGA decode stage: syncs, visible window, pixel coordinates,
// line/frame strobes and a wrapping frame counter, one clock behind the counts.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter int unsigned SYNC_POL  = 0,
   parameter int unsigned FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [9:0]         h_count,
   input  logic [9:0]         v_count,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [9:0]         pixel_x,
   output logic [9:0]         pixel_y,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned CMP_W = cmp_width(H_TOT, V_TOT);

   localparam logic [CMP_W-1:0] H_VIS_L = CMP_W'(H_VISIBLE);
   localparam logic [CMP_W-1:0] H_SS_L  = CMP_W'(H_VISIBLE + H_FP);
   localparam logic [CMP_W-1:0] H_SE_L  = CMP_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CMP_W-1:0] H_TOT_L = CMP_W'(H_TOT);
   localparam logic [CMP_W-1:0] V_VIS_L = CMP_W'(V_VISIBLE);
   localparam logic [CMP_W-1:0] V_SS_L  = CMP_W'(V_VISIBLE + V_FP);
   localparam logic [CMP_W-1:0] V_SE_L  = CMP_W'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [CMP_W-1:0] V_TOT_L = CMP_W'(V_TOT);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   logic [CMP_W-1:0]   h_ext, v_ext;
   logic               h_in, v_in;
   region_t            region;

   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic [9:0]         pixel_x_q, pixel_x_d;
   logic [9:0]         pixel_y_q, pixel_y_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;

   logic               line_edge, frame_edge;

   assign h_ext = CMP_W'(h_count);
   assign v_ext = CMP_W'(v_count);

   // Out-of-range counts fall outside every window, so they decode as blanking.
   always_comb begin
      h_in          = h_ext < H_TOT_L;
      v_in          = v_ext < V_TOT_L;
      region        = '0;
      region.h_vis  = h_in && (h_ext < H_VIS_L);
      region.v_vis  = v_in && (v_ext < V_VIS_L);
      region.h_sync = h_in && (h_ext >= H_SS_L) && (h_ext < H_SE_L);
      region.v_sync = v_in && (v_ext >= V_SS_L) && (v_ext < V_SE_L);

      hsync_d       = region.h_sync ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = region.v_sync ? SYNC_ACT : ~SYNC_ACT;
      video_on_d    = region.h_vis && region.v_vis;
      pixel_x_d     = video_on_d ? h_count : '0;
      pixel_y_d     = video_on_d ? v_count : '0;
      frame_count_d = frame_edge ? frame_count_q + FRAME_W'(1) : frame_count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= ~SYNC_ACT;
         vsync_q       <= ~SYNC_ACT;
         video_on_q    <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         frame_count_q <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         frame_count_q <= frame_count_d;
      end
   end

   vga_edge_strobe #(
      .W         (10),
      .RESET_VAL (SENTINEL)
   ) u_line_strobe (
      .clk_i   (clk),
      .rst_i   (rst),
      .value_i (h_count),
      .edge_o  (line_edge),
      .pulse_o (line_start)
   );

   // Watching {v,h} as one word gives "entered (0,0) unless already there".
   vga_edge_strobe #(
      .W         (20),
      .RESET_VAL ({SENTINEL, SENTINEL})
   ) u_frame_strobe (
      .clk_i   (clk),
      .rst_i   (rst),
      .value_i ({v_count, h_count}),
      .edge_o  (frame_edge),
      .pulse_o (frame_start)
   );

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: table of hand-derived vectors, then sweeps checked
// against a reference model through a scoreboard queue.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       vid;
      logic [9:0] px;
      logic [9:0] py;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [9:0] h;
      logic [9:0] v;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] h_count = '0;
   logic [9:0] v_count = '0;
   logic       hsync, vsync, video_on, line_start, frame_start;
   logic [9:0] pixel_x, pixel_y;
   logic [7:0] frame_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   exp_t       sb_q[$];
   exp_t       last_act;

   logic [9:0] m_prev_h = 10'h3FF;
   logic [9:0] m_prev_v = 10'h3FF;
   logic [7:0] m_fc     = '0;

   always #5 clk = ~clk;

   vga_sync_gen #(
      .H_VISIBLE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
      .V_VISIBLE (480), .V_FP (10), .V_SYNC (2),  .V_BP (33),
      .SYNC_POL  (0),   .FRAME_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .h_count     (h_count),
      .v_count     (v_count),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   task automatic model(input logic r, input logic [9:0] h, input logic [9:0] v,
                        output exp_t e);
      int hi, vi;
      hi = int'(h);
      vi = int'(v);
      e  = '0;
      if (r) begin
         e.hs = 1'b1; e.vs = 1'b1;
         m_prev_h = 10'h3FF; m_prev_v = 10'h3FF; m_fc = '0;
      end else begin
         e.vid = (hi < 640) && (vi < 480);
         e.hs  = !(hi >= 656 && hi < 752);
         e.vs  = !(vi >= 490 && vi < 492);
         e.px  = e.vid ? h : 10'd0;
         e.py  = e.vid ? v : 10'd0;
         e.ls  = (hi == 0) && (m_prev_h != 10'd0);
         e.fs  = (hi == 0) && (vi == 0) && !(m_prev_h == 10'd0 && m_prev_v == 10'd0);
         if (e.fs) m_fc = m_fc + 8'd1;
         e.fc  = m_fc;
         m_prev_h = h; m_prev_v = v;
      end
   endtask

   task automatic apply(input string name, input logic r, input logic [9:0] h,
                        input logic [9:0] v, input logic use_tbl, input exp_t tbl_e);
      exp_t me, want, got;
      model(r, h, v, me);
      sb_q.push_back(use_tbl ? tbl_e : me);
      rst = r; h_count = h; v_count = v;
      @(posedge clk);
      #1;
      got = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, frame_count};
      last_act = got;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = sb_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL %s h=%0d v=%0d: got hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b fc=%0d, want hs=%b vs=%b vid=%b px=%0d py=%0d ls=%b fs=%b fc=%0d",
                     name, h, v, got.hs, got.vs, got.vid, got.px, got.py, got.ls, got.fs, got.fc,
                     want.hs, want.vs, want.vid, want.px, want.py, want.ls, want.fs, want.fc);
         end
      end
   endtask

   task automatic run(input string name, input logic r, input logic [9:0] h, input logic [9:0] v);
      apply(name, r, h, v, 1'b0, '0);
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic r, input int h, input int v,
                               input logic hs, input logic vs, input logic vid,
                               input int px, input int py, input logic ls,
                               input logic fs, input int fc);
      vec_t t;
      t.rst = r; t.h = 10'(h); t.v = 10'(v);
      t.e.hs = hs; t.e.vs = vs; t.e.vid = vid;
      t.e.px = 10'(px); t.e.py = 10'(py);
      t.e.ls = ls; t.e.fs = fs; t.e.fc = 8'(fc);
      return t;
   endfunction

   vec_t tbl [18];

   initial begin
      int hs_low, vid_cnt, vs_low, fs_cnt, strobes, wraps;
      logic [7:0] prev_fc;

      //             rst  h     v     hs vs vid px   py   ls fs fc
      tbl[0]  = mk(1,    5,    5,    1, 1, 0,  0,   0,   0, 0, 0);
      tbl[1]  = mk(0,    0,    0,    1, 1, 1,  0,   0,   1, 1, 1);
      tbl[2]  = mk(0,    1,    0,    1, 1, 1,  1,   0,   0, 0, 1);
      tbl[3]  = mk(0,    639,  479,  1, 1, 1,  639, 479, 0, 0, 1);
      tbl[4]  = mk(0,    640,  479,  1, 1, 0,  0,   0,   0, 0, 1);
      tbl[5]  = mk(0,    655,  10,   1, 1, 0,  0,   0,   0, 0, 1);
      tbl[6]  = mk(0,    656,  10,   0, 1, 0,  0,   0,   0, 0, 1);
      tbl[7]  = mk(0,    751,  10,   0, 1, 0,  0,   0,   0, 0, 1);
      tbl[8]  = mk(0,    752,  10,   1, 1, 0,  0,   0,   0, 0, 1);
      tbl[9]  = mk(0,    0,    489,  1, 1, 0,  0,   0,   1, 0, 1);
      tbl[10] = mk(0,    0,    490,  1, 0, 0,  0,   0,   0, 0, 1);
      tbl[11] = mk(0,    5,    491,  1, 0, 0,  0,   0,   0, 0, 1);
      tbl[12] = mk(0,    5,    492,  1, 1, 0,  0,   0,   0, 0, 1);
      tbl[13] = mk(0,    800,  100,  1, 1, 0,  0,   0,   0, 0, 1);
      tbl[14] = mk(0,    100,  525,  1, 1, 0,  0,   0,   0, 0, 1);
      tbl[15] = mk(0,    1023, 1023, 1, 1, 0,  0,   0,   0, 0, 1);
      tbl[16] = mk(0,    0,    0,    1, 1, 1,  0,   0,   1, 1, 2);
      tbl[17] = mk(0,    0,    0,    1, 1, 1,  0,   0,   0, 0, 2);

      @(posedge clk);
      #1;
      for (int i = 0; i < 18; i++)
         apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].h, tbl[i].v, 1'b1, tbl[i].e);

      // Line sweep at v=100
      hs_low = 0; vid_cnt = 0;
      for (int h = 0; h < 800; h++) begin
         run("hsweep", 1'b0, 10'(h), 10'd100);
         if (!last_act.hs) hs_low++;
         if (last_act.vid) vid_cnt++;
      end
      check_int("hsync_low_clks", hs_low, 96);
      check_int("video_on_clks", vid_cnt, 640);

      // Frame sweep with h parked in the sync window
      vs_low = 0;
      for (int v = 0; v < 525; v++) begin
         run("vsweep", 1'b0, 10'd700, 10'(v));
         if (!last_act.vs) vs_low++;
      end
      check_int("vsync_low_lines", vs_low, 2);

      // Stalled at (0,0)
      fs_cnt = 0;
      prev_fc = frame_count;
      for (int i = 0; i < 5; i++) begin
         run("stall", 1'b0, 10'd0, 10'd0);
         if (last_act.fs) fs_cnt++;
      end
      check_int("stall_frame_pulses", fs_cnt, 1);
      check_int("stall_fc_delta", int'(8'(frame_count - prev_fc)), 1);

      // Frame counter wrap
      wraps = 0;
      for (int i = 0; i < 256; i++) begin
         run("wrap_h1", 1'b0, 10'd1, 10'd0);
         prev_fc = frame_count;
         run("wrap_00", 1'b0, 10'd0, 10'd0);
         if (prev_fc == 8'd255 && frame_count == 8'd0) wraps++;
      end
      check_int("fc_wrap_seen", wraps, 1);

      // Reset mid-frame
      run("mid_pre", 1'b0, 10'd300, 10'd200);
      run("mid_rst", 1'b1, 10'd300, 10'd200);
      check_int("mid_rst_fc", int'(frame_count), 0);
      strobes = 0;
      for (int h = 301; h < 800; h++) begin
         run("mid_resume", 1'b0, 10'(h), 10'd200);
         if (last_act.ls || last_act.fs) strobes++;
      end
      check_int("mid_no_strobes", strobes, 0);
      run("mid_next_line", 1'b0, 10'd0, 10'd201);
      run("mid_next_frame", 1'b0, 10'd0, 10'd0);
      check_int("mid_fc_after", int'(frame_count), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
